// File: rtl/eth_pkg.sv
// Shared types for the Ethernet egress path.
// Covers the 34-bit FIFO word layout and the transmit FSM states.
package eth_pkg;

  localparam int ETH_WORD_W = 34;

  typedef struct packed {
    logic        eop;
    logic        sop;
    logic [31:0] data;
  } eth_word_t;

  typedef enum logic [1:0] {
    IDLE,
    XMIT,
    FLUSH,
    GAP
  } xmt_state_t;

endpackage

// File: rtl/eth_fwft_stage.sv
// Two-entry skid buffer that turns a 1-cycle-latency FIFO into a show-ahead head.
// It keeps reads in flight so that a head popped every cycle stays valid.
module eth_fwft_stage
  import eth_pkg::*;
(
  input  logic      clk,
  input  logic      resetN,
  input  eth_word_t fifoRdData,
  input  logic      fifoEmpty,
  output logic      fifoRdEn,
  input  logic      pop,
  output logic      headValid,
  output eth_word_t headData
);

  logic [1:0] r_count;
  logic       r_inFlight;
  eth_word_t  r_buf0;
  eth_word_t  r_buf1;
  logic       w_pop;
  logic [1:0] w_afterPop;

  assign w_pop      = pop && (r_count != 2'd0);
  assign w_afterPop = r_count - {1'b0, w_pop};
  assign headValid  = (r_count != 2'd0);
  assign headData   = r_buf0;

  // Free space is judged after this cycle's pop, so a drained entry is refilled without a bubble.
  assign fifoRdEn = resetN && !fifoEmpty && ((w_afterPop + {1'b0, r_inFlight}) < 2'd2);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_count    <= 2'd0;
      r_inFlight <= 1'b0;
      r_buf0     <= '0;
      r_buf1     <= '0;
    end else begin
      r_inFlight <= fifoRdEn;
      r_count    <= w_afterPop + {1'b0, r_inFlight};
      if (w_pop) begin
        r_buf0 <= r_buf1;
      end
      if (r_inFlight) begin
        if (w_afterPop == 2'd0) begin
          r_buf0 <= fifoRdData;
        end else begin
          r_buf1 <= fifoRdData;
        end
      end
    end
  end

endmodule

// File: rtl/eth_xmt_fsm.sv
// Egress transmit FSM: sends complete stored packets from the port FIFO as contiguous bursts.
// It enforces the inter-packet gap, the maximum packet length and SOP/EOP framing.
module eth_xmt_fsm
  import eth_pkg::*;
#(
  parameter int MAX_PKT_WORDS = 512,
  parameter int IPG_CYCLES    = 3,
  parameter int PKT_CNT_W     = 6
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic [ETH_WORD_W-1:0] fifoRdData,
  input  logic                  fifoEmpty,
  output logic                  fifoRdEn,
  input  logic                  pktWritten,
  input  logic                  inStall,
  output logic [31:0]           outData,
  output logic                  outSop,
  output logic                  outEop,
  output logic                  outFrameErr,
  output logic [15:0]           outTxPkts
);

  localparam int WC_W  = $clog2(MAX_PKT_WORDS) + 1;
  localparam int GAP_W = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;
  localparam logic [WC_W-1:0]  WC_LAST  = WC_W'(MAX_PKT_WORDS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((IPG_CYCLES > 0) ? IPG_CYCLES - 1 : 0);
  localparam xmt_state_t AFTER_EOP = (IPG_CYCLES == 0) ? IDLE : GAP;

  xmt_state_t           r_state;
  xmt_state_t           w_nextState;
  logic [PKT_CNT_W-1:0] r_pktCnt;
  logic [WC_W-1:0]      r_wordCnt;
  logic [WC_W-1:0]      w_nextWordCnt;
  logic [GAP_W-1:0]     r_gapCnt;
  logic [GAP_W-1:0]     w_nextGapCnt;
  logic                 w_headValid;
  eth_word_t            w_head;
  logic                 w_pop;
  logic                 w_drive;
  logic                 w_sop;
  logic                 w_eop;
  logic                 w_err;
  logic [31:0]          w_data;
  logic                 w_eopPopped;
  logic [31:0]          r_outData;
  logic                 r_outSop;
  logic                 r_outEop;
  logic                 r_outFrameErr;
  logic [15:0]          r_outTxPkts;

  eth_fwft_stage u_fwft (
    .clk        (clk),
    .resetN     (resetN),
    .fifoRdData (fifoRdData),
    .fifoEmpty  (fifoEmpty),
    .fifoRdEn   (fifoRdEn),
    .pop        (w_pop),
    .headValid  (w_headValid),
    .headData   (w_head)
  );

  assign w_eopPopped = w_pop && w_head.eop;

  always_comb begin
    w_nextState   = r_state;
    w_nextWordCnt = r_wordCnt;
    w_nextGapCnt  = '0;
    w_pop         = 1'b0;
    w_drive       = 1'b0;
    w_sop         = 1'b0;
    w_eop         = 1'b0;
    w_err         = 1'b0;
    w_data        = w_head.data;
    case (r_state)
      IDLE: begin
        // Orphan words are dropped as soon as they surface, regardless of stall or stored count.
        if (w_headValid && !w_head.sop) begin
          w_pop = 1'b1;
          w_err = 1'b1;
        end else if (w_headValid && (r_pktCnt != '0) && !inStall) begin
          w_pop         = 1'b1;
          w_drive       = 1'b1;
          w_sop         = 1'b1;
          w_nextWordCnt = WC_W'(1);
          if (w_head.eop) begin
            w_eop       = 1'b1;
            w_nextState = AFTER_EOP;
          end else begin
            w_nextState = XMIT;
          end
        end
      end
      XMIT: begin
        if (w_headValid) begin
          if (w_head.sop) begin
            w_drive     = 1'b1;
            w_data      = '0;
            w_eop       = 1'b1;
            w_err       = 1'b1;
            w_nextState = AFTER_EOP;
          end else begin
            w_pop   = 1'b1;
            w_drive = 1'b1;
            if (w_head.eop) begin
              w_eop       = 1'b1;
              w_nextState = AFTER_EOP;
            end else if (r_wordCnt == WC_LAST) begin
              w_eop       = 1'b1;
              w_err       = 1'b1;
              w_nextState = FLUSH;
            end else begin
              w_nextWordCnt = r_wordCnt + WC_W'(1);
            end
          end
        end
      end
      FLUSH: begin
        if (w_headValid) begin
          if (w_head.sop) begin
            w_nextState = AFTER_EOP;
          end else begin
            w_pop = 1'b1;
            if (w_head.eop) begin
              w_nextState = AFTER_EOP;
            end
          end
        end
      end
      GAP: begin
        if (r_gapCnt == GAP_LAST) begin
          w_nextState = IDLE;
        end else begin
          w_nextGapCnt = r_gapCnt + GAP_W'(1);
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state       <= IDLE;
      r_pktCnt      <= '0;
      r_wordCnt     <= '0;
      r_gapCnt      <= '0;
      r_outData     <= '0;
      r_outSop      <= 1'b0;
      r_outEop      <= 1'b0;
      r_outFrameErr <= 1'b0;
      r_outTxPkts   <= '0;
    end else begin
      r_state       <= w_nextState;
      r_wordCnt     <= w_nextWordCnt;
      r_gapCnt      <= w_nextGapCnt;
      r_outSop      <= w_sop;
      r_outEop      <= w_eop;
      r_outFrameErr <= w_err;
      if (w_drive) begin
        r_outData <= w_data;
      end
      if (w_eop) begin
        r_outTxPkts <= r_outTxPkts + 16'd1;
      end
      if (pktWritten && !w_eopPopped) begin
        r_pktCnt <= r_pktCnt + PKT_CNT_W'(1);
      end else if (!pktWritten && w_eopPopped) begin
        r_pktCnt <= r_pktCnt - PKT_CNT_W'(1);
      end
    end
  end

  assign outData     = r_outData;
  assign outSop      = r_outSop;
  assign outEop      = r_outEop;
  assign outFrameErr = r_outFrameErr;
  assign outTxPkts   = r_outTxPkts;

endmodule

// File: tb/tb_eth_xmt_fsm.sv
// Scoreboard bench for eth_xmt_fsm with a behavioural 1-cycle-latency FIFO model.
// Expected egress events are queued with the stimulus and checked by a forked monitor.
module tb_eth_xmt_fsm;

  localparam int IPG = 3;

  logic        clk         = 1'b0;
  logic        resetN      = 1'b0;
  logic [33:0] fifoRdData  = '0;
  logic        fifoEmpty   = 1'b1;
  logic        fifoRdEn;
  logic        pktWritten  = 1'b0;
  logic        inStall     = 1'b0;
  logic [31:0] outData;
  logic        outSop;
  logic        outEop;
  logic        outFrameErr;
  logic [15:0] outTxPkts;

  logic        wrEn      = 1'b0;
  logic [33:0] wrData    = '0;
  logic        fifoFlush = 1'b0;
  logic [33:0] fifoQ[$];
  logic [34:0] expQ[$];
  int          nChecks = 0;
  int          nFail   = 0;
  int          expTx   = 0;
  int          cycle   = 0;

  eth_xmt_fsm #(
    .MAX_PKT_WORDS (4),
    .IPG_CYCLES    (IPG),
    .PKT_CNT_W     (6)
  ) dut (
    .clk         (clk),
    .resetN      (resetN),
    .fifoRdData  (fifoRdData),
    .fifoEmpty   (fifoEmpty),
    .fifoRdEn    (fifoRdEn),
    .pktWritten  (pktWritten),
    .inStall     (inStall),
    .outData     (outData),
    .outSop      (outSop),
    .outEop      (outEop),
    .outFrameErr (outFrameErr),
    .outTxPkts   (outTxPkts)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // FIFO model: read data appears the cycle after fifoRdEn, empty flag is registered.
  always @(posedge clk) begin
    if (fifoFlush) begin
      fifoQ.delete();
    end else begin
      if (fifoRdEn && fifoQ.size() > 0) fifoRdData <= fifoQ.pop_front();
      if (wrEn) fifoQ.push_back(wrData);
    end
    fifoEmpty <= (fifoQ.size() == 0);
  end

  task automatic checkOutput(input string name, input logic [39:0] got, input logic [39:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [33:0] w, input logic pw);
    wrEn       = wr;
    wrData     = w;
    pktWritten = pw;
    @(negedge clk);
    wrEn       = 1'b0;
    pktWritten = 1'b0;
  endtask

  task automatic writePkt(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b1, {(i == n - 1), (i == 0), base + 32'(i)}, (i == n - 1));
  endtask

  task automatic expectBeat(input logic sop, input logic eop, input logic err, input logic [31:0] d);
    expQ.push_back({sop, eop, err, d});
    if (eop) expTx++;
  endtask

  task automatic expectPkt(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) expectBeat((i == 0), (i == n - 1), 1'b0, base + 32'(i));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitDrain(input string name, input int maxCyc);
    int k = 0;
    while (expQ.size() != 0 && k < maxCyc) begin
      @(negedge clk);
      #1;
      k++;
    end
    nChecks++;
    if (expQ.size() != 0) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d events still pending after %0d cycles, required 0", name, expQ.size(), maxCyc);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "Sop"},  40'(outSop),      40'd0);
    checkOutput({tag, "Eop"},  40'(outEop),      40'd0);
    checkOutput({tag, "Err"},  40'(outFrameErr), 40'd0);
    checkOutput({tag, "Data"}, 40'(outData),     40'd0);
    checkOutput({tag, "Tx"},   40'(outTxPkts),   40'd0);
    checkOutput({tag, "RdEn"}, 40'(fifoRdEn),    40'd0);
  endtask

  // Every SOP, in-packet word or error pulse must match the head of the expected queue.
  task automatic monitorLoop();
    logic        inPkt   = 1'b0;
    logic        haveEop = 1'b0;
    int          lastEop = 0;
    logic [34:0] got;
    logic [34:0] exp;
    forever begin
      @(negedge clk);
      if (!resetN) begin
        inPkt   = 1'b0;
        haveEop = 1'b0;
      end else begin
        if (outSop || inPkt || outFrameErr) begin
          got = {outSop, outEop, outFrameErr, outData};
          if (expQ.size() == 0) begin
            nChecks++;
            nFail++;
            $display("[TB] FAIL unexpectedBeat: got sop/eop/err/data %h, required no output", got);
          end else begin
            exp = expQ.pop_front();
            checkOutput("beat", 40'(got), 40'(exp));
          end
        end
        if (outSop && haveEop) begin
          nChecks++;
          if (cycle - lastEop < IPG + 1) begin
            nFail++;
            $display("[TB] FAIL interPacketGap: got %0d cycles, required >= %0d", cycle - lastEop, IPG + 1);
          end
        end
        if (outSop && !outEop) inPkt = 1'b1;
        if (outEop) begin
          inPkt   = 1'b0;
          haveEop = 1'b1;
          lastEop = cycle;
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int k;
    fork
      monitorLoop();
    join_none

    repeat (3) @(negedge clk);
    checkReset("init");
    resetN = 1'b1;
    idle(2);

    // Basic 3-word packet.
    expectPkt(32'h0000_00A0, 3);
    writePkt(32'h0000_00A0, 3);
    waitDrain("basicDrain", 40);
    idle(6);
    checkOutput("basicTx", 40'(outTxPkts), 40'(expTx));

    // Two packets held by stall, then stall raised during the first one.
    inStall = 1'b1;
    writePkt(32'h1000_0000, 3);
    writePkt(32'h2000_0000, 2);
    idle(12);
    checkOutput("stalledTx", 40'(outTxPkts), 40'(expTx));
    expectPkt(32'h1000_0000, 3);
    inStall = 1'b0;
    k = 0;
    while (!outSop && k < 30) begin
      @(negedge clk);
      #1;
      k++;
    end
    checkOutput("stallReleaseSop", 40'(outSop), 40'd1);
    inStall = 1'b1;
    waitDrain("stallPkt1", 30);
    idle(12);
    checkOutput("stallHoldTx", 40'(outTxPkts), 40'(expTx));
    expectPkt(32'h2000_0000, 2);
    inStall = 1'b0;
    waitDrain("stallPkt2", 40);
    idle(6);

    // Single-word packet.
    expectBeat(1'b1, 1'b1, 1'b0, 32'h0000_ABCD);
    applyStimulus(1'b1, {1'b1, 1'b1, 32'h0000_ABCD}, 1'b1);
    waitDrain("singleWord", 40);
    idle(6);

    // Orphan word: error pulse, outData keeps the previous word.
    expectBeat(1'b0, 1'b0, 1'b1, 32'h0000_ABCD);
    expectPkt(32'hC0DE_0000, 2);
    applyStimulus(1'b1, {2'b00, 32'h0000_1234}, 1'b0);
    writePkt(32'hC0DE_0000, 2);
    waitDrain("orphan", 40);
    idle(6);

    // Missing EOP: forced zero-data EOP, the next SOP starts a fresh packet.
    expectBeat(1'b1, 1'b0, 1'b0, 32'hB000_0000);
    expectBeat(1'b0, 1'b0, 1'b0, 32'hB000_0001);
    expectBeat(1'b0, 1'b1, 1'b1, 32'h0000_0000);
    expectPkt(32'hCC00_0000, 2);
    applyStimulus(1'b1, {2'b01, 32'hB000_0000}, 1'b0);
    applyStimulus(1'b1, {2'b00, 32'hB000_0001}, 1'b0);
    writePkt(32'hCC00_0000, 2);
    waitDrain("missingEop", 60);
    idle(6);

    // Over-length packet truncated at 4 words, remainder flushed.
    expectBeat(1'b1, 1'b0, 1'b0, 32'hD000_0000);
    expectBeat(1'b0, 1'b0, 1'b0, 32'hD000_0001);
    expectBeat(1'b0, 1'b0, 1'b0, 32'hD000_0002);
    expectBeat(1'b0, 1'b1, 1'b1, 32'hD000_0003);
    expectPkt(32'hE000_0000, 2);
    writePkt(32'hD000_0000, 6);
    writePkt(32'hE000_0000, 2);
    waitDrain("truncate", 60);
    idle(6);
    checkOutput("totalTx", 40'(outTxPkts), 40'(expTx));

    // Asynchronous reset in the middle of a packet.
    expectBeat(1'b1, 1'b0, 1'b0, 32'hF000_0000);
    expectBeat(1'b0, 1'b0, 1'b0, 32'hF000_0001);
    writePkt(32'hF000_0000, 4);
    waitDrain("preReset", 40);
    #1;
    resetN    = 1'b0;
    fifoFlush = 1'b1;
    #1;
    checkReset("async");
    expTx = 0;
    @(negedge clk);
    @(negedge clk);
    fifoFlush = 1'b0;
    resetN    = 1'b1;
    idle(2);

    // Stored-packet count must restart from zero: no send until pktWritten arrives.
    applyStimulus(1'b1, {1'b1, 1'b1, 32'h0000_5A5A}, 1'b0);
    idle(12);
    checkOutput("postResetHoldTx", 40'(outTxPkts), 40'd0);
    expectBeat(1'b1, 1'b1, 1'b0, 32'h0000_5A5A);
    applyStimulus(1'b0, '0, 1'b1);
    waitDrain("postReset", 40);
    idle(6);
    checkOutput("postResetTx", 40'(outTxPkts), 40'(expTx));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
